painterengine_gpu_dma_reader: RTL and testbench

Upstream DMA stage of the GPU datapath: fetches a linear block of 32-bit words from memory over an AXI4 full read master and streams them to one of four consumer channels using the same lane-packed data/valid/next stream format that the GPU DMA writer consumes. It runs one job per reset and selects its channel with a one-hot router. It splits the job into INCR bursts that never cross a 1 KB boundary, and buffers returned beats in a small FIFO so that consumer stalls back-pressure RREADY.

---
 rtl/painterengine_gpu_dma_pkg.sv | 53 +++++
 rtl/painterengine_gpu_dma_fifo.sv | 60 ++++++
 rtl/painterengine_gpu_dma_reader.sv | 245 ++++++++++++++++++++++++
 tb/tb_painterengine_gpu_dma_reader.sv | 396 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_dma_pkg.sv
// Shared definitions for the GPU DMA reader and writer: FSM state
// encodings, error codes, fixed AXI attributes and the 1 KB burst limit.
package painterengine_gpu_dma_pkg;

  // Bit 4 marks the terminal error states so a single bit test suffices.
  typedef enum logic [4:0] {
    ST_ROUTING     = 5'h00,
    ST_PARAM_CHECK = 5'h01,
    ST_CALC        = 5'h02,
    ST_ADDR_READ   = 5'h03,
    ST_DATA_READ   = 5'h04,
    ST_DRAIN       = 5'h05,
    ST_DONE        = 5'h06,
    ST_ERR_ROUTING = 5'h11,
    ST_ERR_ALIGN   = 5'h12,
    ST_ERR_LENGTH  = 5'h13,
    ST_ERR_TIMEOUT = 5'h14,
    ST_ERR_RRESP   = 5'h15,
    ST_ERR_RLAST   = 5'h16
  } dma_state_e;

  localparam logic [2:0] ERR_TYPE_NONE    = 3'd0;
  localparam logic [2:0] ERR_TYPE_ROUTING = 3'd1;
  localparam logic [2:0] ERR_TYPE_ALIGN   = 3'd2;
  localparam logic [2:0] ERR_TYPE_LENGTH  = 3'd3;
  localparam logic [2:0] ERR_TYPE_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_TYPE_RRESP   = 3'd5;
  localparam logic [2:0] ERR_TYPE_RLAST   = 3'd6;

  localparam logic [2:0] AXI_SIZE_32    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [3:0] AXI_CACHE      = 4'b0010;

  // 1 KB of 32-bit words: no burst may cross this boundary.
  localparam logic [8:0] BOUNDARY_WORDS = 9'd256;

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic [2:0] error_code(input dma_state_e s);
    case (s)
      ST_ERR_ROUTING: return ERR_TYPE_ROUTING;
      ST_ERR_ALIGN:   return ERR_TYPE_ALIGN;
      ST_ERR_LENGTH:  return ERR_TYPE_LENGTH;
      ST_ERR_TIMEOUT: return ERR_TYPE_TIMEOUT;
      ST_ERR_RRESP:   return ERR_TYPE_RRESP;
      ST_ERR_RLAST:   return ERR_TYPE_RLAST;
      default:        return ERR_TYPE_NONE;
    endcase
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_fifo.sv
// Synchronous 32-bit FIFO, head visible one cycle after the push edge.
// Storage is left unreset; only pointers and occupancy are cleared.
module painterengine_gpu_dma_fifo #(
  parameter int PARAM_DEPTH = 16
) (
  input  logic                         i_wire_clock,
  input  logic                         i_wire_resetn,
  input  logic                         push,
  input  logic [31:0]                  push_data,
  input  logic                         pop,
  output logic [31:0]                  pop_data,
  output logic [$clog2(PARAM_DEPTH):0] count,
  output logic                         empty,
  output logic                         full
);

  localparam int AW = $clog2(PARAM_DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = PARAM_DEPTH;

  logic [31:0]   mem [PARAM_DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign empty    = (count_reg == '0);
  assign full     = (count_reg == CNT_MAX);
  assign count    = count_reg;
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr_reg];

  // Write accepted beats into storage.
  always_ff @(posedge i_wire_clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Advance pointers and occupancy; simultaneous push and pop keeps count.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/painterengine_gpu_dma_reader.sv
// GPU DMA reader: fetches one linear block per reset over AXI4 INCR bursts
// (split at 1 KB boundaries, one burst in flight) and streams the words to
// the one-hot selected consumer lane through a small FIFO.
module painterengine_gpu_dma_reader
  import painterengine_gpu_dma_pkg::*;
#(
  parameter int PARAM_FIFO_DEPTH = 16,
  parameter int PARAM_TIMEOUT    = 256
) (
  input  logic         i_wire_clock,
  input  logic         i_wire_resetn,
  input  logic [3:0]   i_wire_router,
  input  logic [127:0] i_wire_address,
  input  logic [127:0] i_wire_length,
  output logic [127:0] o_wire_data,
  output logic [3:0]   o_wire_data_valid,
  input  logic [3:0]   i_wire_data_next,
  output logic         o_wire_done,
  output logic         o_wire_error,
  output logic [2:0]   o_wire_error_type,
  output logic         o_wire_M_AXI_ARID,
  output logic [31:0]  o_wire_M_AXI_ARADDR,
  output logic [7:0]   o_wire_M_AXI_ARLEN,
  output logic [2:0]   o_wire_M_AXI_ARSIZE,
  output logic [1:0]   o_wire_M_AXI_ARBURST,
  output logic         o_wire_M_AXI_ARLOCK,
  output logic [3:0]   o_wire_M_AXI_ARCACHE,
  output logic [2:0]   o_wire_M_AXI_ARPROT,
  output logic [3:0]   o_wire_M_AXI_ARQOS,
  output logic         o_wire_M_AXI_ARVALID,
  input  logic         i_wire_M_AXI_ARREADY,
  input  logic         i_wire_M_AXI_RID,
  input  logic [31:0]  i_wire_M_AXI_RDATA,
  input  logic [1:0]   i_wire_M_AXI_RRESP,
  input  logic         i_wire_M_AXI_RLAST,
  input  logic         i_wire_M_AXI_RVALID,
  output logic         o_wire_M_AXI_RREADY
);

  localparam int CW = $clog2(PARAM_FIFO_DEPTH) + 1;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(PARAM_TIMEOUT);

  dma_state_e  state_reg, state_next;
  logic [3:0]  sel_reg, sel_next;
  logic [31:0] cur_addr_reg, cur_addr_next;
  logic [31:0] remaining_reg, remaining_next;
  logic [8:0]  burstlen_reg, burstlen_next;
  logic [8:0]  beat_cnt_reg, beat_cnt_next;
  logic [31:0] araddr_reg, araddr_next;
  logic [7:0]  arlen_reg, arlen_next;
  logic        arvalid_reg, arvalid_next;
  logic [15:0] timeout_reg, timeout_next;

  logic [31:0] lane_addr [4];
  logic [31:0] lane_len [4];
  logic [31:0] sel_addr;
  logic [31:0] sel_len;
  logic [8:0]  boundary_left;
  logic [8:0]  calc_len;
  logic [8:0]  calc_len_m1;
  logic [15:0] timeout_inc;
  logic        ar_hs;
  logic        r_hs;
  logic        stalled;
  logic        timeout_hit;
  logic        beat_last;

  logic          rready;
  logic          fifo_pop;
  logic [31:0]   fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic          fifo_full;
  logic [3:0]    data_valid;
  logic          unused_inputs;

  painterengine_gpu_dma_fifo #(
    .PARAM_DEPTH (PARAM_FIFO_DEPTH)
  ) u_fifo (
    .i_wire_clock  (i_wire_clock),
    .i_wire_resetn (i_wire_resetn),
    .push          (r_hs),
    .push_data     (i_wire_M_AXI_RDATA),
    .pop           (fifo_pop),
    .pop_data      (fifo_head),
    .count         (fifo_count),
    .empty         (fifo_empty),
    .full          (fifo_full)
  );

  // Per-lane parameter select and output steering by the one-hot router.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_addr[gi]  = sel_reg[gi] ? i_wire_address[32*gi +: 32] : 32'd0;
    assign lane_len[gi]   = sel_reg[gi] ? i_wire_length[32*gi +: 32]  : 32'd0;
    assign data_valid[gi] = sel_reg[gi] && !fifo_empty && !state_reg[4];
    assign o_wire_data[32*gi +: 32] = data_valid[gi] ? fifo_head : 32'd0;
  end

  assign sel_addr = lane_addr[0] | lane_addr[1] | lane_addr[2] | lane_addr[3];
  assign sel_len  = lane_len[0]  | lane_len[1]  | lane_len[2]  | lane_len[3];

  assign rready   = (state_reg == ST_DATA_READ) && !fifo_full;
  assign fifo_pop = |(data_valid & i_wire_data_next);
  assign ar_hs    = arvalid_reg && i_wire_M_AXI_ARREADY;
  assign r_hs     = rready && i_wire_M_AXI_RVALID;

  // Burst sizing: words left before the next 1 KB line, capped by remaining.
  assign boundary_left = BOUNDARY_WORDS - {1'b0, cur_addr_reg[9:2]};
  assign calc_len      = (remaining_reg < {23'd0, boundary_left}) ? remaining_reg[8:0] : boundary_left;
  assign calc_len_m1   = calc_len - 9'd1;

  assign stalled     = (arvalid_reg && !i_wire_M_AXI_ARREADY) || (rready && !i_wire_M_AXI_RVALID);
  assign timeout_inc = timeout_reg + 16'd1;
  assign timeout_hit = stalled && (timeout_inc == TIMEOUT_LIMIT);
  assign beat_last   = (beat_cnt_reg == burstlen_reg - 9'd1);

  // Next-state logic for the job FSM, burst bookkeeping and stall timer.
  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    burstlen_next  = burstlen_reg;
    beat_cnt_next  = beat_cnt_reg;
    araddr_next    = araddr_reg;
    arlen_next     = arlen_reg;
    arvalid_next   = arvalid_reg;
    timeout_next   = timeout_reg;

    if (ar_hs || r_hs) begin
      timeout_next = 16'd0;
    end else if (stalled) begin
      timeout_next = timeout_inc;
    end

    case (state_reg)
      ST_ROUTING: begin
        if (is_onehot4(i_wire_router)) begin
          sel_next   = i_wire_router;
          state_next = ST_PARAM_CHECK;
        end else begin
          state_next = ST_ERR_ROUTING;
        end
      end
      ST_PARAM_CHECK: begin
        if (sel_addr[1:0] != 2'b00) begin
          state_next = ST_ERR_ALIGN;
        end else if (sel_len == 32'd0) begin
          state_next = ST_ERR_LENGTH;
        end else begin
          cur_addr_next  = sel_addr;
          remaining_next = sel_len;
          state_next     = ST_CALC;
        end
      end
      ST_CALC: begin
        burstlen_next  = calc_len;
        araddr_next    = cur_addr_reg;
        arlen_next     = calc_len_m1[7:0];
        remaining_next = remaining_reg - {23'd0, calc_len};
        beat_cnt_next  = 9'd0;
        state_next     = ST_ADDR_READ;
      end
      ST_ADDR_READ: begin
        if (ar_hs) begin
          arvalid_next = 1'b0;
          state_next   = ST_DATA_READ;
        end else if (timeout_hit) begin
          arvalid_next = 1'b0;
          state_next   = ST_ERR_TIMEOUT;
        end else begin
          arvalid_next = 1'b1;
        end
      end
      ST_DATA_READ: begin
        if (r_hs) begin
          beat_cnt_next = beat_cnt_reg + 9'd1;
          if (i_wire_M_AXI_RRESP[1]) begin
            state_next = ST_ERR_RRESP;
          end else if (i_wire_M_AXI_RLAST != beat_last) begin
            state_next = ST_ERR_RLAST;
          end else if (beat_last) begin
            cur_addr_next = cur_addr_reg + {21'd0, burstlen_reg, 2'b00};
            state_next    = (remaining_reg == 32'd0) ? ST_DRAIN : ST_CALC;
          end
        end else if (timeout_hit) begin
          state_next = ST_ERR_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) state_next = ST_DONE;
      end
      default: begin
        arvalid_next = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset.
  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_reg     <= ST_ROUTING;
      sel_reg       <= 4'd0;
      cur_addr_reg  <= 32'd0;
      remaining_reg <= 32'd0;
      burstlen_reg  <= 9'd0;
      beat_cnt_reg  <= 9'd0;
      araddr_reg    <= 32'd0;
      arlen_reg     <= 8'd0;
      arvalid_reg   <= 1'b0;
      timeout_reg   <= 16'd0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      burstlen_reg  <= burstlen_next;
      beat_cnt_reg  <= beat_cnt_next;
      araddr_reg    <= araddr_next;
      arlen_reg     <= arlen_next;
      arvalid_reg   <= arvalid_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign o_wire_data_valid    = data_valid;
  assign o_wire_done          = (state_reg == ST_DONE);
  assign o_wire_error         = state_reg[4];
  assign o_wire_error_type    = error_code(state_reg);
  assign o_wire_M_AXI_ARID    = 1'b0;
  assign o_wire_M_AXI_ARADDR  = araddr_reg;
  assign o_wire_M_AXI_ARLEN   = arlen_reg;
  assign o_wire_M_AXI_ARSIZE  = AXI_SIZE_32;
  assign o_wire_M_AXI_ARBURST = AXI_BURST_INCR;
  assign o_wire_M_AXI_ARLOCK  = 1'b0;
  assign o_wire_M_AXI_ARCACHE = AXI_CACHE;
  assign o_wire_M_AXI_ARPROT  = 3'd0;
  assign o_wire_M_AXI_ARQOS   = 4'd0;
  assign o_wire_M_AXI_ARVALID = arvalid_reg;
  assign o_wire_M_AXI_RREADY  = rready;

  // RID and the low RRESP bit carry no information for a single-ID reader.
  assign unused_inputs = &{1'b0, i_wire_M_AXI_RID, i_wire_M_AXI_RRESP[0], fifo_count};

endmodule

// File: tb/tb_painterengine_gpu_dma_reader.sv
// Bench for the GPU DMA reader: AXI slave memory, consumer, and a model
// that derives the expected AR sequence and word stream from the job.
module tb_painterengine_gpu_dma_reader;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         resetn;
  logic [3:0]   router;
  logic [127:0] address, length, data;
  logic [3:0]   data_valid, data_next;
  logic         done, error;
  logic [2:0]   error_type;
  logic         arid, arlock, arvalid, arready, rid, rlast, rvalid, rready;
  logic [31:0]  araddr, rdata;
  logic [7:0]   arlen;
  logic [2:0]   arsize, arprot;
  logic [1:0]   arburst, rresp;
  logic [3:0]   arcache, arqos;

  painterengine_gpu_dma_reader #(.PARAM_FIFO_DEPTH(DEPTH), .PARAM_TIMEOUT(256)) dut (
    .i_wire_clock(clk), .i_wire_resetn(resetn), .i_wire_router(router),
    .i_wire_address(address), .i_wire_length(length), .o_wire_data(data),
    .o_wire_data_valid(data_valid), .i_wire_data_next(data_next),
    .o_wire_done(done), .o_wire_error(error), .o_wire_error_type(error_type),
    .o_wire_M_AXI_ARID(arid), .o_wire_M_AXI_ARADDR(araddr), .o_wire_M_AXI_ARLEN(arlen),
    .o_wire_M_AXI_ARSIZE(arsize), .o_wire_M_AXI_ARBURST(arburst), .o_wire_M_AXI_ARLOCK(arlock),
    .o_wire_M_AXI_ARCACHE(arcache), .o_wire_M_AXI_ARPROT(arprot), .o_wire_M_AXI_ARQOS(arqos),
    .o_wire_M_AXI_ARVALID(arvalid), .i_wire_M_AXI_ARREADY(arready),
    .i_wire_M_AXI_RID(rid), .i_wire_M_AXI_RDATA(rdata), .i_wire_M_AXI_RRESP(rresp),
    .i_wire_M_AXI_RLAST(rlast), .i_wire_M_AXI_RVALID(rvalid), .o_wire_M_AXI_RREADY(rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  // Memory contents seen by the slave.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  // Model: expected ARs and words for a job, from the burst-splitting rule.
  logic [31:0] exp_ar_addr[$];
  logic [7:0]  exp_ar_len[$];
  logic [31:0] exp_w[$];
  logic [3:0]  exp_lane;

  task automatic plan(input logic [31:0] a, input int len);
    int rem;
    int room;
    int bl;
    logic [31:0] cur;
    cur = a;
    rem = len;
    while (rem > 0) begin
      room = 256 - int'((cur >> 2) & 32'hFF);
      bl = (rem < room) ? rem : room;
      exp_ar_addr.push_back(cur);
      exp_ar_len.push_back(8'(bl - 1));
      cur = cur + 32'(bl * 4);
      rem = rem - bl;
    end
    for (int i = 0; i < len; i++) exp_w.push_back(mem_word(a + 32'(4 * i)));
  endtask

  // Stimulus controls and observation counters.
  bit ar_en = 1'b1;
  bit r_en = 1'b1;
  bit cons_en = 1'b1;
  int rresp_err_beat = -1;
  int rlast_early_beat = -1;
  int ar_count = 0, arvalid_cycles = 0, pop_cnt = 0, rhs_count = 0, occ = 0;

  assign data_next = cons_en ? 4'hF : 4'h0;

  // AXI slave: one burst queue, beats returned back to back when enabled.
  initial begin
    logic        s_ar_hs, s_r_hs;
    logic [31:0] s_addr;
    logic [7:0]  s_len;
    logic [31:0] slv_addr[$];
    int          slv_len[$];
    int          beat_idx, job_beat;
    beat_idx = 0;
    job_beat = 0;
    arready = 1'b0; rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rid = 1'b0;
    forever begin
      @(negedge clk);
      s_ar_hs = resetn && arvalid && arready;
      s_r_hs  = resetn && rvalid && rready;
      s_addr  = araddr;
      s_len   = arlen;
      @(posedge clk);
      #1;
      if (!resetn) begin
        slv_addr.delete();
        slv_len.delete();
        beat_idx = 0;
        job_beat = 0;
      end else begin
        if (s_r_hs && slv_len.size() > 0) begin
          job_beat++;
          if (beat_idx == slv_len[0]) begin
            void'(slv_addr.pop_front());
            void'(slv_len.pop_front());
            beat_idx = 0;
          end else begin
            beat_idx++;
          end
        end
        if (s_ar_hs) begin
          slv_addr.push_back(s_addr);
          slv_len.push_back(int'(s_len));
        end
      end
      arready = ar_en;
      if (slv_len.size() > 0) begin
        rvalid = r_en;
        rdata  = mem_word(slv_addr[0] + 32'(4 * beat_idx));
        rlast  = (beat_idx == slv_len[0]) || (job_beat == rlast_early_beat);
        rresp  = (job_beat == rresp_err_beat) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
    end
  end

  // Compare process: checks DUT outputs against the model every cycle.
  initial begin
    logic        prev_arvalid, prev_ar_hs, popped;
    logic [31:0] prev_araddr;
    logic [7:0]  prev_arlen;
    prev_arvalid = 1'b0; prev_ar_hs = 1'b0; prev_araddr = 32'd0; prev_arlen = 8'd0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        occ = 0;
        prev_arvalid = 1'b0;
        prev_ar_hs = 1'b0;
      end else begin
        check("valid_lane", {28'd0, data_valid & ~exp_lane}, 32'd0);
        for (int i = 0; i < 4; i++)
          if (!exp_lane[i]) check("idle_lane_data", data[32*i +: 32], 32'd0);
        if (!error) check("valid_vs_occ", {31'd0, |data_valid}, {31'd0, occ > 0});
        if (arvalid) arvalid_cycles++;
        if (prev_arvalid && arvalid && !prev_ar_hs) begin
          check("araddr_stable", araddr, prev_araddr);
          check("arlen_stable", {24'd0, arlen}, {24'd0, prev_arlen});
        end
        if (arvalid && arready) begin
          ar_count++;
          if (exp_ar_addr.size() == 0) begin
            fail_now("unexpected_ar");
          end else begin
            check("ar_addr", araddr, exp_ar_addr.pop_front());
            check("ar_len", {24'd0, arlen}, {24'd0, exp_ar_len.pop_front()});
            check("ar_fixed", {arid, arsize, arburst, arlock, arcache, arprot, arqos},
                  {1'b0, 3'b010, 2'b01, 1'b0, 4'b0010, 3'd0, 4'd0});
          end
        end
        if (rready) check("rready_room", {31'd0, occ < DEPTH}, 32'd1);
        popped = 1'b0;
        for (int i = 0; i < 4; i++) begin
          if (data_valid[i] && data_next[i]) begin
            popped = 1'b1;
            pop_cnt++;
            if (exp_w.size() == 0) fail_now("unexpected_word");
            else check("word", data[32*i +: 32], exp_w.pop_front());
          end
        end
        if (rready && rvalid) begin
          rhs_count++;
          occ++;
        end
        if (popped) occ--;
        prev_arvalid = arvalid;
        prev_ar_hs = arvalid && arready;
        prev_araddr = araddr;
        prev_arlen = arlen;
      end
    end
  end

  // Put the DUT in reset, program a job and build expectations.
  task automatic start_job(input logic [3:0] r, input int lane, input logic [31:0] a,
                           input int len, input bit plan_it);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    router = r;
    for (int i = 0; i < 4; i++) begin
      address[32*i +: 32] = 32'hDEAD_0003 + 32'(i * 16);
      length[32*i +: 32]  = 32'd5;
    end
    address[32*lane +: 32] = a;
    length[32*lane +: 32]  = 32'(len);
    exp_lane = r;
    exp_ar_addr.delete();
    exp_ar_len.delete();
    exp_w.delete();
    if (plan_it) plan(a, len);
    repeat (2) @(posedge clk);
    #1;
    ar_count = 0; arvalid_cycles = 0; pop_cnt = 0; rhs_count = 0;
  endtask

  task automatic release_reset();
    resetn = 1'b1;
  endtask

  task automatic wait_end(input int budget, input string name);
    int n;
    n = 0;
    while (!(done || error) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) fail_now(name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arvalid"}, {31'd0, arvalid}, 32'd0);
    check({tag, "_rready"}, {31'd0, rready}, 32'd0);
    check({tag, "_araddr"}, araddr, 32'd0);
    check({tag, "_arlen"}, {24'd0, arlen}, 32'd0);
    check({tag, "_data"}, {31'd0, |data}, 32'd0);
    check({tag, "_valid"}, {28'd0, data_valid}, 32'd0);
    check({tag, "_done_err"}, {30'd0, done, error}, 32'd0);
    check({tag, "_error_type"}, {29'd0, error_type}, 32'd0);
  endtask

  initial begin
    int n;
    resetn = 1'b0;
    router = 4'd0;
    address = '0;
    length = '0;
    exp_lane = 4'd0;

    // Job 1: single burst on lane 1, also checks reset values and AR timing.
    start_job(4'b0010, 1, 32'h0000_1000, 8, 1'b1);
    check("pin1_count", 32'(exp_ar_addr.size()), 32'd1);
    check("pin1_addr", exp_ar_addr[0], 32'h0000_1000);
    check("pin1_len", {24'd0, exp_ar_len[0]}, 32'd7);
    check_reset_outputs("reset");
    release_reset();
    repeat (3) @(posedge clk);
    #1;
    check("arvalid_edge3", {31'd0, arvalid}, 32'd0);
    @(posedge clk);
    #1;
    check("arvalid_edge4", {31'd0, arvalid}, 32'd1);
    wait_end(500, "job1_end");
    check("job1_done", {30'd0, done, error}, 32'd2);
    check("job1_error_type", {29'd0, error_type}, 32'd0);
    check("job1_ars", 32'(ar_count), 32'd1);
    check("job1_words", 32'(pop_cnt), 32'd8);

    // Job 2: crosses two 1 KB boundaries on lane 2.
    start_job(4'b0100, 2, 32'h0000_13F0, 300, 1'b1);
    check("pin2_count", 32'(exp_ar_addr.size()), 32'd3);
    check("pin2_addr0", exp_ar_addr[0], 32'h0000_13F0);
    check("pin2_len0", {24'd0, exp_ar_len[0]}, 32'd3);
    check("pin2_addr1", exp_ar_addr[1], 32'h0000_1400);
    check("pin2_len1", {24'd0, exp_ar_len[1]}, 32'd255);
    check("pin2_addr2", exp_ar_addr[2], 32'h0000_1800);
    check("pin2_len2", {24'd0, exp_ar_len[2]}, 32'd39);
    release_reset();
    wait_end(3000, "job2_end");
    check("job2_done", {30'd0, done, error}, 32'd2);
    check("job2_ars", 32'(ar_count), 32'd3);
    check("job2_words", 32'(pop_cnt), 32'd300);

    // Job 3: consumer stall inside a 64-beat burst on lane 3.
    start_job(4'b1000, 3, 32'h0000_2000, 64, 1'b1);
    release_reset();
    n = 0;
    while (pop_cnt < 4 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) fail_now("stall_start");
    cons_en = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check("stall_rready", {31'd0, rready}, 32'd0);
    check("stall_no_error", {31'd0, error}, 32'd0);
    check("stall_occ", 32'(occ), 32'd16);
    cons_en = 1'b1;
    wait_end(1000, "job3_end");
    check("job3_done", {30'd0, done, error}, 32'd2);
    check("job3_words", 32'(pop_cnt), 32'd64);

    // Parameter errors: no AR may be issued.
    start_job(4'b0011, 0, 32'h0000_1000, 8, 1'b0);
    release_reset();
    wait_end(50, "route_end");
    check("route_error_type", {29'd0, error_type}, 32'd1);
    check("route_no_ar", 32'(arvalid_cycles), 32'd0);

    start_job(4'b0001, 0, 32'h0000_1002, 8, 1'b0);
    release_reset();
    wait_end(50, "align_end");
    check("align_error_type", {29'd0, error_type}, 32'd2);
    check("align_no_ar", 32'(arvalid_cycles), 32'd0);

    start_job(4'b0001, 0, 32'h0000_1000, 0, 1'b0);
    release_reset();
    wait_end(50, "length_end");
    check("length_error_type", {29'd0, error_type}, 32'd3);
    check("length_no_ar", 32'(arvalid_cycles), 32'd0);

    // Slave error response on the third beat.
    rresp_err_beat = 2;
    start_job(4'b0001, 0, 32'h0000_3000, 8, 1'b1);
    release_reset();
    wait_end(100, "rresp_end");
    repeat (20) @(posedge clk);
    #1;
    check("rresp_error_type", {29'd0, error_type}, 32'd5);
    check("rresp_rready", {31'd0, rready}, 32'd0);
    check("rresp_ars", 32'(ar_count), 32'd1);
    check("rresp_pops", 32'(pop_cnt), 32'd2);
    rresp_err_beat = -1;

    // Early RLAST on beat 2 of 4.
    rlast_early_beat = 1;
    start_job(4'b0001, 0, 32'h0000_3000, 4, 1'b1);
    release_reset();
    wait_end(100, "rlast_end");
    check("rlast_error_type", {29'd0, error_type}, 32'd6);
    rlast_early_beat = -1;

    // ARREADY never given.
    ar_en = 1'b0;
    start_job(4'b0001, 0, 32'h0000_3000, 8, 1'b1);
    release_reset();
    wait_end(400, "timeout_end");
    repeat (5) @(posedge clk);
    #1;
    check("timeout_error_type", {29'd0, error_type}, 32'd4);
    check("timeout_cycles", 32'(arvalid_cycles), 32'd256);
    ar_en = 1'b1;

    // Reset in the middle of a burst.
    start_job(4'b0001, 0, 32'h0000_4000, 64, 1'b1);
    release_reset();
    n = 0;
    while (pop_cnt < 10 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) fail_now("midreset_start");
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk);
    #1;
    check_reset_outputs("midreset_edge");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
